// File: rtl/spawn_pkg.sv
// Shared constants and state encoding for the spawn placer.
// Play field geometry is in pixels; the grid is 25x25 tiles of 16 px.
package spawn_pkg;
  localparam int PLAY_X0    = 120;
  localparam int PLAY_Y0    = 48;
  localparam int TILE_SHIFT = 4;
  localparam int GRID_DIM   = 25;
  localparam int TILE_HALF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    LOOKUP,
    CHECK,
    DONE,
    FAIL
  } spawn_state_t;
endpackage

// File: rtl/spawn_placer_pix_to_tile.sv
// Pixel coordinate to tile index, clamped to 0..GRID_DIM-1.
// Purely combinational.
module pix_to_tile
  import spawn_pkg::*;
#(
  parameter int N      = 9,
  parameter int ORIGIN = 120
) (
  input  logic [N:0] pix,
  output logic [4:0] tile
);

  localparam int RW = N - TILE_SHIFT + 1;

  logic [N:0]    off;
  logic [RW-1:0] raw;

  always_comb begin
    off  = pix - (N+1)'(ORIGIN);
    raw  = RW'(off >> TILE_SHIFT);
    tile = '0;
    if (pix < (N+1)'(ORIGIN)) begin
      tile = '0;
    end else if (raw > RW'(GRID_DIM - 1)) begin
      tile = 5'(GRID_DIM - 1);
    end else begin
      tile = raw[4:0];
    end
  end

endmodule

// File: rtl/spawn_placer.sv
// Random spawn tile picker with wall ROM check and bounded retries.
// Define SPAWN_PAC_EXCLUDE_EN to also reject tiles near PacMan.
module spawn_placer
  import spawn_pkg::*;
#(
  parameter int N         = 9,
  parameter int MAX_TRIES = 8,
  parameter int MIN_DIST  = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       spawn_req,
  input  logic [N:0] X_rand,
  input  logic [N:0] Y_rand,
  input  logic [N:0] pac_x,
  input  logic [N:0] pac_y,
  output logic       tile_rd_en,
  output logic [9:0] tile_addr,
  input  logic       tile_data,
  output logic       busy,
  output logic       spawn_valid,
  output logic       spawn_fail,
  output logic [N:0] spawn_x,
  output logic [N:0] spawn_y
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] MAXT = TW'(MAX_TRIES);

  spawn_state_t  state_q, state_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [TW-1:0] tries_inc;
  logic [4:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [N:0]    sx_q, sx_d;
  logic [N:0]    sy_q, sy_d;
  logic [4:0]    cand_col, cand_row;
  logic [9:0]    addr;
  logic          reject;

  pix_to_tile #(.N(N), .ORIGIN(PLAY_X0)) u_cand_x (
    .pix  (X_rand),
    .tile (cand_col)
  );

  pix_to_tile #(.N(N), .ORIGIN(PLAY_Y0)) u_cand_y (
    .pix  (Y_rand),
    .tile (cand_row)
  );

`ifdef SPAWN_PAC_EXCLUDE_EN
  localparam logic [6:0] MIN_D = 7'(MIN_DIST);

  logic [4:0] pac_col, pac_row;
  logic [4:0] pcol_q, pcol_d;
  logic [4:0] prow_q, prow_d;
  logic [6:0] dcol, drow;
  logic       too_close;

  // pac_x/pac_y share the candidate's clamp rules
  pix_to_tile #(.N(N), .ORIGIN(PLAY_X0)) u_pac_x (
    .pix  (pac_x),
    .tile (pac_col)
  );

  pix_to_tile #(.N(N), .ORIGIN(PLAY_Y0)) u_pac_y (
    .pix  (pac_y),
    .tile (pac_row)
  );

  always_comb begin
    dcol = (col_q >= pcol_q) ? 7'(col_q - pcol_q)
                             : 7'(pcol_q - col_q);
    drow = (row_q >= prow_q) ? 7'(row_q - prow_q)
                             : 7'(prow_q - row_q);
    too_close = (dcol + drow) < MIN_D;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pcol_q <= '0;
      prow_q <= '0;
    end else begin
      pcol_q <= pcol_d;
      prow_q <= prow_d;
    end
  end

  always_comb begin
    pcol_d = pcol_q;
    prow_d = prow_q;
    if (state_q == SAMPLE) begin
      pcol_d = pac_col;
      prow_d = pac_row;
    end
  end

  assign reject = tile_data | too_close;
`else
  logic unused_pac;
  assign unused_pac = ^{pac_x, pac_y};
  assign reject     = tile_data;
`endif

  assign addr      = 10'(row_q) * 10'(GRID_DIM) + 10'(col_q);
  assign tries_inc = tries_q + TW'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      tries_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tries_d     = tries_q;
    col_d       = col_q;
    row_d       = row_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    tile_rd_en  = 1'b0;
    tile_addr   = '0;
    busy        = (state_q != IDLE);
    spawn_valid = 1'b0;
    spawn_fail  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (spawn_req) begin
          state_d = SAMPLE;
          tries_d = '0;
        end
      end
      SAMPLE: begin
        col_d   = cand_col;
        row_d   = cand_row;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        tile_rd_en = 1'b1;
        tile_addr  = addr;
        state_d    = CHECK;
      end
      CHECK: begin
        if (!reject) begin
          sx_d = (N+1)'(PLAY_X0 + TILE_HALF)
               + ((N+1)'(col_q) << TILE_SHIFT);
          sy_d = (N+1)'(PLAY_Y0 + TILE_HALF)
               + ((N+1)'(row_q) << TILE_SHIFT);
          state_d = DONE;
        end else begin
          tries_d = tries_inc;
          state_d = (tries_inc == MAXT) ? FAIL : SAMPLE;
        end
      end
      DONE: begin
        spawn_valid = 1'b1;
        state_d     = IDLE;
      end
      FAIL: begin
        spawn_fail = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign spawn_x = sx_q;
  assign spawn_y = sy_q;

endmodule

// File: tb/tb_spawn_placer.sv
// Directed bench for spawn_placer with a registered wall ROM model.
// Expectations follow SPAWN_PAC_EXCLUDE_EN when it is defined.
module tb_spawn_placer;

  localparam int N = 9;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       spawn_req = 1'b0;
  logic [N:0] X_rand = '0;
  logic [N:0] Y_rand = '0;
  logic [N:0] pac_x = '0;
  logic [N:0] pac_y = '0;
  logic       tile_rd_en;
  logic [9:0] tile_addr;
  logic       tile_data;
  logic       busy;
  logic       spawn_valid;
  logic       spawn_fail;
  logic [N:0] spawn_x;
  logic [N:0] spawn_y;

  logic wall [0:624];
  int vectors = 0;
  int miscompares = 0;

  int         lat;
  int         lookups;
  int         pulses;
  logic [9:0] last_addr;
  logic       got_valid;

  spawn_placer #(.N(N), .MAX_TRIES(8), .MIN_DIST(4)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .spawn_req   (spawn_req),
    .X_rand      (X_rand),
    .Y_rand      (Y_rand),
    .pac_x       (pac_x),
    .pac_y       (pac_y),
    .tile_rd_en  (tile_rd_en),
    .tile_addr   (tile_addr),
    .tile_data   (tile_data),
    .busy        (busy),
    .spawn_valid (spawn_valid),
    .spawn_fail  (spawn_fail),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) tile_data <= 1'b0;
    else if (tile_rd_en) tile_data <= wall[tile_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_maze(input logic v);
    for (int i = 0; i < 625; i++) wall[i] = v;
  endtask

  // one-cycle request; returns in cycle n+1
  task automatic issue();
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
  endtask

  task automatic wait_pulse(input int start, output int l,
                            output int lk, output logic [9:0] la,
                            output logic gv);
    l = start; lk = 0; la = '0; gv = 1'b0;
    while (!spawn_valid && !spawn_fail && l < 200) begin
      step();
      l++;
      if (tile_rd_en) begin
        lk++;
        la = tile_addr;
      end
    end
    check("pulse_seen", 32'(spawn_valid | spawn_fail), 1);
    check("pulse_excl", 32'(spawn_valid & spawn_fail), 0);
    gv = spawn_valid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_maze(1'b0);
    step();
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(spawn_valid), 0);
    check("rst_fail", 32'(spawn_fail), 0);
    check("rst_rden", 32'(tile_rd_en), 0);
    check("rst_sx", 32'(spawn_x), 0);
    check("rst_sy", 32'(spawn_y), 0);
    Reset_n = 1'b1;
    step();

    // open maze, (300,200) -> tile (11,9)
    X_rand = 10'd300; Y_rand = 10'd200;
    issue();
    check("t1_busy", 32'(busy), 1);
    check("t1_rden_n1", 32'(tile_rd_en), 0);
    step();
    check("t1_rden_n2", 32'(tile_rd_en), 1);
    check("t1_addr", 32'(tile_addr), 236);
    step();
    check("t1_valid_n3", 32'(spawn_valid), 0);
    step();
    check("t1_valid_n4", 32'(spawn_valid), 1);
    check("t1_fail_n4", 32'(spawn_fail), 0);
    check("t1_sx", 32'(spawn_x), 304);
    check("t1_sy", 32'(spawn_y), 200);
    step();
    check("t1_valid_drop", 32'(spawn_valid), 0);
    check("t1_idle", 32'(busy), 0);

    // wall on first candidate, retry lands on (1,9)
    wall[236] = 1'b1;
    X_rand = 10'd300;
    issue();
    step();
    X_rand = 10'd136;
    wait_pulse(2, lat, lookups, last_addr, got_valid);
    check("t2_lat", 32'(lat), 7);
    check("t2_valid", 32'(got_valid), 1);
    check("t2_addr", 32'(last_addr), 226);
    check("t2_sx", 32'(spawn_x), 144);
    check("t2_sy", 32'(spawn_y), 200);
    step();

    // every tile is a wall: budget exhausted
    set_maze(1'b1);
    X_rand = 10'd300;
    issue();
    wait_pulse(1, lat, lookups, last_addr, got_valid);
    check("t3_lat", 32'(lat), 25);
    check("t3_lookups", 32'(lookups), 8);
    check("t3_valid", 32'(got_valid), 0);
    check("t3_fail", 32'(spawn_fail), 1);
    check("t3_sx_hold", 32'(spawn_x), 144);
    check("t3_sy_hold", 32'(spawn_y), 200);
    step();
    check("t3_fail_drop", 32'(spawn_fail), 0);

    // upper bound clamps to tile 24
    set_maze(1'b0);
    X_rand = 10'd520; Y_rand = 10'd448;
    issue();
    wait_pulse(1, lat, lookups, last_addr, got_valid);
    check("t4_lat", 32'(lat), 4);
    check("t4_addr", 32'(last_addr), 624);
    check("t4_sx", 32'(spawn_x), 512);
    check("t4_sy", 32'(spawn_y), 440);
    step();

    // below-origin clamps to tile 0
    X_rand = 10'd0; Y_rand = 10'd200;
    issue();
    wait_pulse(1, lat, lookups, last_addr, got_valid);
    check("t4b_addr", 32'(last_addr), 225);
    check("t4b_sx", 32'(spawn_x), 128);
    check("t4b_sy", 32'(spawn_y), 200);
    step();

    // reset during LOOKUP
    X_rand = 10'd300; Y_rand = 10'd200;
    issue();
    step();
    check("t5_in_lookup", 32'(tile_rd_en), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 0);
    check("t5_rden", 32'(tile_rd_en), 0);
    check("t5_addr", 32'(tile_addr), 0);
    check("t5_sx", 32'(spawn_x), 0);
    check("t5_sy", 32'(spawn_y), 0);
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (spawn_valid || spawn_fail || busy) pulses++;
    end
    check("t5_quiet", 32'(pulses), 0);

    // PacMan exclusion zone
    pac_x = 10'd304; pac_y = 10'd200;
    X_rand = 10'd300; Y_rand = 10'd200;
    issue();
    step();
    X_rand = 10'd136;
    wait_pulse(2, lat, lookups, last_addr, got_valid);
`ifdef SPAWN_PAC_EXCLUDE_EN
    check("t6_lat", 32'(lat), 7);
    check("t6_sx", 32'(spawn_x), 144);
`else
    check("t6_lat", 32'(lat), 4);
    check("t6_sx", 32'(spawn_x), 304);
`endif
    check("t6_valid", 32'(got_valid), 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
